// File: rtl/l2_mem_bist_pkg.sv
// Shared types and constants for the L2 SRAM bank BIST initiator.
package l2_mem_bist_pkg;

  // Sequencer states; the encoding is visible on the debug state output.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } bist_state_e;

  // Operation select values carried on mode_i.
  localparam logic [1:0] MODE_FILL        = 2'd0;
  localparam logic [1:0] MODE_FILL_VERIFY = 2'd1;
  localparam logic [1:0] MODE_VERIFY      = 2'd2;
  localparam logic [1:0] MODE_RSVD        = 2'd3;

endpackage

// File: rtl/l2_mem_bist_checker.sv
// Read-data checker: delays the expected word by one cycle so it lines up
// with Q, compares, captures the first failure and counts mismatches.
module l2_mem_bist_checker #(
  parameter int ADDR_WIDTH    = 15,
  parameter int DATA_WIDTH    = 32,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  input  logic                     rd_issue_i,
  input  logic [ADDR_WIDTH-1:0]    rd_addr_i,
  input  logic [DATA_WIDTH-1:0]    rd_exp_i,
  input  logic [DATA_WIDTH-1:0]    q_i,
  output logic                     fail_o,
  output logic [ADDR_WIDTH-1:0]    fail_addr_o,
  output logic [DATA_WIDTH-1:0]    fail_data_o,
  output logic [ERR_CNT_WIDTH-1:0] err_count_o
);

  logic                     cmp_vld_q;
  logic [ADDR_WIDTH-1:0]    cmp_addr_q;
  logic [DATA_WIDTH-1:0]    cmp_exp_q;
  logic                     fail_q, fail_d;
  logic [ADDR_WIDTH-1:0]    fail_addr_q, fail_addr_d;
  logic [DATA_WIDTH-1:0]    fail_data_q, fail_data_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic                     mismatch;

  // Q belongs to the read issued in the previous cycle.
  assign mismatch = cmp_vld_q && (q_i != cmp_exp_q);

  // Next status: a new operation clears; otherwise record first fail and count.
  always_comb begin
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    err_cnt_d   = err_cnt_q;
    if (clear_i) begin
      fail_d      = 1'b0;
      fail_addr_d = '0;
      fail_data_d = '0;
      err_cnt_d   = '0;
    end else if (mismatch) begin
      if (!fail_q) begin
        fail_d      = 1'b1;
        fail_addr_d = cmp_addr_q;
        fail_data_d = q_i;
      end
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
    end
  end

  // Expected-data delay stage and status registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cmp_vld_q   <= 1'b0;
      cmp_addr_q  <= '0;
      cmp_exp_q   <= '0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      cmp_vld_q   <= rd_issue_i;
      cmp_addr_q  <= rd_addr_i;
      cmp_exp_q   <= rd_exp_i;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign fail_o      = fail_q;
  assign fail_addr_o = fail_addr_q;
  assign fail_data_o = fail_data_q;
  assign err_count_o = err_cnt_q;

endmodule

// File: rtl/l2_mem_bist_initiator.sv
// L2 SRAM bank BIST initiator: fills the bank with pattern ^ address and/or
// reads every word back for checking. Bank outputs are registered and are
// computed from next-state values so they line up with state_q/addr_q.
// Handshake: start_i is a one-cycle request, accepted only in IDLE or DONE;
// busy_o is high while the operation runs and done_o is the sticky completion.
module l2_mem_bist_initiator
  import l2_mem_bist_pkg::*;
#(
  parameter int ADDR_WIDTH    = 15,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_WORDS     = 28672,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     start_i,
  input  logic [1:0]               mode_i,
  input  logic [DATA_WIDTH-1:0]    pattern_i,
  input  logic                     abort_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     aborted_o,
  output logic                     fail_o,
  output logic [ADDR_WIDTH-1:0]    fail_addr_o,
  output logic [DATA_WIDTH-1:0]    fail_data_o,
  output logic [ERR_CNT_WIDTH-1:0] err_count_o,
  output logic                     CEN,
  output logic                     WEN,
  output logic [DATA_WIDTH/8-1:0]  BEN,
  output logic [ADDR_WIDTH-1:0]    A,
  output logic [DATA_WIDTH-1:0]    D,
  input  logic [DATA_WIDTH-1:0]    Q,
  output logic [2:0]               state_o
);

  // Compare against the last valid address so a full 2**ADDR_WIDTH bank never wraps.
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);

  bist_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [1:0]              mode_q, mode_d;
  logic [DATA_WIDTH-1:0]   pattern_q, pattern_d;
  logic                    done_q, done_d;
  logic                    aborted_q, aborted_d;
  logic                    cen_q, cen_d;
  logic                    wen_q, wen_d;
  logic [ADDR_WIDTH-1:0]   a_q, a_d;
  logic [DATA_WIDTH-1:0]   d_q, d_d;
  logic                    accept;
  logic                    bank_active;

  assign accept = start_i && (state_q == IDLE || state_q == DONE);

  // Next-state, address generation and registered bank-port values.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    mode_d    = mode_q;
    pattern_d = pattern_q;
    done_d    = done_q;
    aborted_d = aborted_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          mode_d    = mode_i;
          pattern_d = pattern_i;
          addr_d    = '0;
          done_d    = 1'b0;
          aborted_d = 1'b0;
          case (mode_i)
            MODE_FILL, MODE_FILL_VERIFY: state_d = WRITE;
            MODE_VERIFY:                 state_d = READ;
            default: begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          endcase
        end
      end
      WRITE: begin
        if (abort_i) begin
          state_d   = DONE;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end else if (addr_q == LAST_ADDR) begin
          addr_d = '0;
          if (mode_q == MODE_FILL) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = READ;
          end
        end else begin
          addr_d = addr_q + ADDR_WIDTH'(1);
        end
      end
      READ: begin
        if (abort_i) begin
          state_d   = DONE;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end else if (addr_q == LAST_ADDR) begin
          state_d = DRAIN;
        end else begin
          addr_d = addr_q + ADDR_WIDTH'(1);
        end
      end
      DRAIN: begin
        state_d   = DONE;
        done_d    = 1'b1;
        aborted_d = abort_i;
      end
      default: state_d = IDLE;
    endcase

    bank_active = (state_d == WRITE) || (state_d == READ);
    cen_d = !bank_active;
    wen_d = (state_d != WRITE);
    a_d   = bank_active ? addr_d : a_q;
    d_d   = (state_d == WRITE) ? (pattern_d ^ DATA_WIDTH'(addr_d)) : d_q;
  end

  // State, latched operands, sticky flags and bank-port registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      mode_q    <= MODE_FILL;
      pattern_q <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      cen_q     <= 1'b1;
      wen_q     <= 1'b1;
      a_q       <= '0;
      d_q       <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      mode_q    <= mode_d;
      pattern_q <= pattern_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      cen_q     <= cen_d;
      wen_q     <= wen_d;
      a_q       <= a_d;
      d_q       <= d_d;
    end
  end

  l2_mem_bist_checker #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH),
    .ERR_CNT_WIDTH(ERR_CNT_WIDTH)
  ) u_checker (
    .clk_i      (CLK),
    .rst_i      (RST),
    .clear_i    (accept),
    .rd_issue_i (!cen_q && wen_q),
    .rd_addr_i  (a_q),
    .rd_exp_i   (pattern_q ^ DATA_WIDTH'(a_q)),
    .q_i        (Q),
    .fail_o     (fail_o),
    .fail_addr_o(fail_addr_o),
    .fail_data_o(fail_data_o),
    .err_count_o(err_count_o)
  );

  assign busy_o    = (state_q == WRITE) || (state_q == READ) || (state_q == DRAIN);
  assign done_o    = done_q;
  assign aborted_o = aborted_q;
  assign CEN       = cen_q;
  assign WEN       = wen_q;
  assign BEN       = '0;
  assign A         = a_q;
  assign D         = d_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_l2_mem_bist_initiator.sv
// Bench for l2_mem_bist_initiator: 16-word bank model with 1-cycle read
// latency, per-address read corruption and an all-zeros read mode.
module tb_l2_mem_bist_initiator;
  import l2_mem_bist_pkg::*;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int NW = 16;
  localparam int EW = 2;
  localparam int W  = 4 + 1 + AW + DW;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          start_i = 1'b0;
  logic [1:0]    mode_i = 2'd0;
  logic [DW-1:0] pattern_i = '0;
  logic          abort_i = 1'b0;
  logic          busy_o, done_o, aborted_o, fail_o;
  logic [AW-1:0] fail_addr_o;
  logic [DW-1:0] fail_data_o;
  logic [EW-1:0] err_count_o;
  logic          CEN, WEN;
  logic [3:0]    BEN;
  logic [AW-1:0] A;
  logic [DW-1:0] D;
  logic [DW-1:0] Q;
  logic [2:0]    state_o;

  l2_mem_bist_initiator #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WORDS(NW), .ERR_CNT_WIDTH(EW)
  ) dut (
    .CLK(CLK), .RST(RST), .start_i(start_i), .mode_i(mode_i),
    .pattern_i(pattern_i), .abort_i(abort_i), .busy_o(busy_o),
    .done_o(done_o), .aborted_o(aborted_o), .fail_o(fail_o),
    .fail_addr_o(fail_addr_o), .fail_data_o(fail_data_o),
    .err_count_o(err_count_o), .CEN(CEN), .WEN(WEN), .BEN(BEN), .A(A),
    .D(D), .Q(Q), .state_o(state_o)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  // ---------------- bank model ----------------
  logic [DW-1:0] mem  [NW];
  logic [DW-1:0] mask [NW];
  bit            zero_mode = 1'b0;

  always @(posedge CLK) begin
    if (!CEN) begin
      if (!WEN) mem[A] <= D;
      else      Q <= zero_mode ? '0 : (mem[A] ^ mask[A]);
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int            busy;
    bit            aborted;
    bit            fail;
    logic [AW-1:0] faddr;
    logic [DW-1:0] fdata;
    logic [EW-1:0] err;
  } stat_t;

  logic [W-1:0] exp_q[$];
  stat_t        stat_q[$];
  int           n_vec = 0;
  int           n_err = 0;
  int           busy_cnt = 0;
  bit           done_prev = 1'b0;
  int           snap_req = 0;
  int           snap_seen = 0;
  int           timeout_req = 0;
  bit           end_req = 1'b0;
  bit           end_ack = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: bank accesses, completion status, reset snapshots, end checks.
  always @(negedge CLK) begin
    logic [W-1:0] act;
    stat_t        s;
    if (!CEN) begin
      act = {BEN, WEN, A, (WEN ? 32'h0 : D)};
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_access: got 0x%0h, expected no access (t=%0t)", act, $time);
      end else begin
        chk("bank_access", 64'(act), 64'(exp_q.pop_front()));
      end
    end
    if (RST) busy_cnt = 0;
    else if (busy_o) busy_cnt++;
    if (done_o && !done_prev) begin
      if (stat_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got done, expected none (t=%0t)", $time);
      end else begin
        s = stat_q.pop_front();
        chk("done_state",  64'(state_o),     64'(DONE));
        chk("done_cen",    64'(CEN),         64'd1);
        chk("done_busy",   64'(busy_o),      64'd0);
        chk("busy_cycles", 64'(busy_cnt),    64'(s.busy));
        chk("aborted",     64'(aborted_o),   64'(s.aborted));
        chk("fail",        64'(fail_o),      64'(s.fail));
        chk("fail_addr",   64'(fail_addr_o), 64'(s.faddr));
        chk("fail_data",   64'(fail_data_o), 64'(s.fdata));
        chk("err_count",   64'(err_count_o), 64'(s.err));
      end
      busy_cnt = 0;
    end
    if (snap_req != snap_seen) begin
      snap_seen = snap_req;
      chk("rst_state",     64'(state_o),     64'(IDLE));
      chk("rst_cen",       64'(CEN),         64'd1);
      chk("rst_wen",       64'(WEN),         64'd1);
      chk("rst_ben",       64'(BEN),         64'd0);
      chk("rst_a",         64'(A),           64'd0);
      chk("rst_d",         64'(D),           64'd0);
      chk("rst_busy",      64'(busy_o),      64'd0);
      chk("rst_done",      64'(done_o),      64'd0);
      chk("rst_aborted",   64'(aborted_o),   64'd0);
      chk("rst_fail",      64'(fail_o),      64'd0);
      chk("rst_fail_addr", 64'(fail_addr_o), 64'd0);
      chk("rst_fail_data", 64'(fail_data_o), 64'd0);
      chk("rst_err_count", 64'(err_count_o), 64'd0);
    end
    if (end_req && !end_ack) begin
      chk("leftover_accesses", 64'(exp_q.size()),  64'd0);
      chk("leftover_status",   64'(stat_q.size()), 64'd0);
      chk("wait_timeouts",     64'(timeout_req),   64'd0);
      end_ack = 1'b1;
    end
    done_prev = done_o;
  end

  // ---------------- driver tasks ----------------
  task automatic push_writes(input logic [DW-1:0] pat, input int n);
    for (int i = 0; i < n; i++) begin
      logic [AW-1:0] a;
      a = AW'(i);
      exp_q.push_back({4'h0, 1'b0, a, pat ^ DW'(a)});
    end
  endtask

  task automatic push_reads(input int n);
    for (int i = 0; i < n; i++) begin
      logic [AW-1:0] a;
      a = AW'(i);
      exp_q.push_back({4'h0, 1'b1, a, 32'h0});
    end
  endtask

  task automatic push_stat(input int busy, input bit ab, input bit fl,
                           input logic [AW-1:0] fa, input logic [DW-1:0] fd,
                           input logic [EW-1:0] ec);
    stat_t s;
    s.busy = busy; s.aborted = ab; s.fail = fl; s.faddr = fa; s.fdata = fd; s.err = ec;
    stat_q.push_back(s);
  endtask

  task automatic run_op(input logic [1:0] mode, input logic [DW-1:0] pat);
    @(negedge CLK);
    start_i = 1'b1; mode_i = mode; pattern_i = pat;
    @(negedge CLK);
    start_i = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done_o && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (!done_o) timeout_req++;
    repeat (2) @(negedge CLK);
  endtask

  task automatic wait_addr(input logic [AW-1:0] a);
    int n = 0;
    while (!(!CEN && A == a) && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 100) timeout_req++;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < NW; i++) mask[i] = '0;

    // Reset values.
    repeat (3) @(posedge CLK);
    #1 snap_req++;
    @(negedge CLK);
    RST = 1'b0;

    // FILL; a start during the operation is ignored.
    push_writes(32'hA5A5_0000, NW);
    push_stat(NW, 0, 0, '0, '0, '0);
    run_op(MODE_FILL, 32'hA5A5_0000);
    wait_addr(4'd4);
    start_i = 1'b1; mode_i = MODE_VERIFY;
    @(negedge CLK);
    start_i = 1'b0;
    wait_done();

    // FILL_VERIFY, clean memory: 16 writes + 16 reads + drain.
    push_writes(32'hFFFF_FFFF, NW);
    push_reads(NW);
    push_stat(2 * NW + 1, 0, 0, '0, '0, '0);
    run_op(MODE_FILL_VERIFY, 32'hFFFF_FFFF);
    wait_done();

    // VERIFY with corrupted words 5 (bit 3) and 9.
    mask[5] = 32'h0000_0008;
    mask[9] = 32'h0000_0100;
    push_reads(NW);
    push_stat(NW + 1, 0, 1, 4'd5, 32'hFFFF_FFF2, 2'd2);
    run_op(MODE_VERIFY, 32'hFFFF_FFFF);
    wait_done();
    mask[5] = '0;
    mask[9] = '0;

    // VERIFY against an all-zero bank: counter saturates at 3.
    zero_mode = 1'b1;
    push_reads(NW);
    push_stat(NW + 1, 0, 1, 4'd0, 32'h0, 2'd3);
    run_op(MODE_VERIFY, 32'hFFFF_FFFF);
    wait_done();
    zero_mode = 1'b0;

    // Abort while writing address 7.
    push_writes(32'h1234_5678, 8);
    push_stat(8, 1, 0, '0, '0, '0);
    run_op(MODE_FILL, 32'h1234_5678);
    wait_addr(4'd7);
    abort_i = 1'b1;
    @(negedge CLK);
    abort_i = 1'b0;
    wait_done();

    // Following FILL_VERIFY clears the abort and runs a full pass.
    push_writes(32'h0F0F_0F0F, NW);
    push_reads(NW);
    push_stat(2 * NW + 1, 0, 0, '0, '0, '0);
    run_op(MODE_FILL_VERIFY, 32'h0F0F_0F0F);
    wait_done();

    // Reset during READ at address 10.
    push_reads(11);
    run_op(MODE_VERIFY, 32'h0F0F_0F0F);
    wait_addr(4'd10);
    RST = 1'b1;
    @(posedge CLK);
    #1 snap_req++;
    repeat (2) @(negedge CLK);
    RST = 1'b0;

    // Reserved mode: done with no bank access.
    push_stat(0, 0, 0, '0, '0, '0);
    run_op(MODE_RSVD, 32'hDEAD_BEEF);
    wait_done();

    end_req = 1'b1;
    for (int i = 0; i < 10 && !end_ack; i++) @(negedge CLK);
    @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
